// File: rtl/stack_alu_issuer_if.sv
// rtl/stack_alu_issuer_if.sv - command, ALU and status bundle of the stack ALU issuer
interface stack_alu_issuer_if #(
  parameter int CW = 5
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [15:0]   cmd_data;
  logic [3:0]    alu_func;
  logic [15:0]   alu_i0;
  logic [15:0]   alu_i1;
  logic [15:0]   alu_o0;
  logic [15:0]   top;
  logic [CW-1:0] depth;
  logic          op_done;
  logic          err_under;
  logic          err_over;
  logic          err_ill;

  modport master (
    output cmd_valid, cmd_op, cmd_data, alu_o0,
    input  cmd_ready, alu_func, alu_i0, alu_i1, top, depth,
    input  op_done, err_under, err_over, err_ill
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, alu_o0,
    output cmd_ready, alu_func, alu_i0, alu_i1, top, depth,
    output op_done, err_under, err_over, err_ill
  );
endinterface

// File: rtl/stack_alu_issuer.sv
// rtl/stack_alu_issuer.sv - operand stack sequencer driving a combinational ALU
module stack_alu_issuer #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rst,
  stack_alu_issuer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;

  typedef enum logic [2:0] {IDLE, FETCH_B, FETCH_A, EXEC, WB} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] depth_q, depth_d;
  logic [15:0]   a_q, a_d;
  logic [15:0]   b_q, b_d;
  logic [15:0]   res_q, res_d;
  logic [2:0]    op_q, op_d;
  logic [3:0]    alu_func_q, alu_func_d;
  logic          op_done_q, op_done_d;
  logic          err_under_q, err_under_d;
  logic          err_over_q, err_over_d;
  logic          err_ill_q, err_ill_d;

  logic [15:0]   stack_q [DEPTH];
  logic          stack_we;
  logic [15:0]   stack_wdata;
  logic [AW-1:0] stack_waddr;
  logic [AW-1:0] top_idx;
  logic [15:0]   top_w;
  logic          full;
  logic          cmd_fire;

  assign top_idx     = AW'(depth_q - CW'(1));
  assign top_w       = (depth_q == '0) ? 16'd0 : stack_q[top_idx];
  assign stack_waddr = AW'(depth_q);
  assign full        = (depth_q == CW'(DEPTH));

  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;

  assign bus.alu_func  = alu_func_q;
  assign bus.alu_i0    = a_q;
  assign bus.alu_i1    = b_q;
  assign bus.top       = top_w;
  assign bus.depth     = depth_q;
  assign bus.op_done   = op_done_q;
  assign bus.err_under = err_under_q;
  assign bus.err_over  = err_over_q;
  assign bus.err_ill   = err_ill_q;

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    op_d        = op_q;
    alu_func_d  = 4'd0;
    op_done_d   = 1'b0;
    err_under_d = 1'b0;
    err_over_d  = 1'b0;
    err_ill_d   = 1'b0;
    stack_we    = 1'b0;
    stack_wdata = bus.cmd_data;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          case (bus.cmd_op)
            OP_PUSH: begin
              if (!full) begin
                stack_we  = 1'b1;
                depth_d   = depth_q + CW'(1);
                op_done_d = 1'b1;
              end else begin
                err_over_d = 1'b1;
              end
            end
            OP_POP: begin
              if (depth_q != '0) begin
                depth_d   = depth_q - CW'(1);
                op_done_d = 1'b1;
              end else begin
                err_under_d = 1'b1;
              end
            end
            3'd2, 3'd3, 3'd4, 3'd5: begin
              if (depth_q < CW'(2)) begin
                err_under_d = 1'b1;
              end else begin
                op_d    = bus.cmd_op;
                state_d = FETCH_B;
              end
            end
            default: err_ill_d = 1'b1;
          endcase
        end
      end
      FETCH_B: begin
        b_d     = top_w;
        depth_d = depth_q - CW'(1);
        state_d = FETCH_A;
      end
      FETCH_A: begin
        a_d        = top_w;
        depth_d    = depth_q - CW'(1);
        // Function code is registered so it is live exactly for the EXEC cycle.
        alu_func_d = {1'b0, op_q};
        state_d    = EXEC;
      end
      EXEC: begin
        res_d   = bus.alu_o0;
        state_d = WB;
      end
      WB: begin
        stack_we    = 1'b1;
        stack_wdata = res_q;
        depth_d     = depth_q + CW'(1);
        op_done_d   = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      op_q        <= '0;
      alu_func_q  <= '0;
      op_done_q   <= 1'b0;
      err_under_q <= 1'b0;
      err_over_q  <= 1'b0;
      err_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      op_q        <= op_d;
      alu_func_q  <= alu_func_d;
      op_done_q   <= op_done_d;
      err_under_q <= err_under_d;
      err_over_q  <= err_over_d;
      err_ill_q   <= err_ill_d;
    end
  end

  // Storage is not reset; depth alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (stack_we) stack_q[stack_waddr] <= stack_wdata;
  end
endmodule

// File: tb/tb_stack_alu_issuer.sv
// tb/tb_stack_alu_issuer.sv - randomized self-checking bench for stack_alu_issuer
module tb_stack_alu_issuer;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_alu_issuer_if #(.CW(CW)) bus();
  stack_alu_issuer #(.DEPTH(DEPTH), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] alu_res;
  always_comb begin
    case (bus.alu_func)
      4'd2:    alu_res = bus.alu_i0 + bus.alu_i1;
      4'd3:    alu_res = bus.alu_i0 - bus.alu_i1;
      4'd4:    alu_res = bus.alu_i0 * bus.alu_i1;
      4'd5:    alu_res = (bus.alu_i1 == 16'd0) ? 16'hFFFF : bus.alu_i0 / bus.alu_i1;
      default: alu_res = bus.alu_i0;
    endcase
  end
  assign bus.alu_o0 = alu_res;

  int total = 0;
  int bad   = 0;
  logic [15:0] mq[$];

  function automatic logic [3:0] flags();
    return {bus.op_done, bus.err_under, bus.err_over, bus.err_ill};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int busy, output int exec_n, output logic [3:0] f,
                           output logic [15:0] i0, output logic [15:0] i1);
    busy = 0; exec_n = 0; f = 4'd0; i0 = 16'd0; i1 = 16'd0;
    while (!bus.cmd_ready && busy < 20) begin
      if (bus.alu_func != 4'd0) begin
        exec_n++; f = bus.alu_func; i0 = bus.alu_i0; i1 = bus.alu_i1;
      end
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bus.cmd_ready); end
    total++; if (bus.depth !== CW'(0)) begin bad++; $display("FAIL rst_depth got=%0d want=0", bus.depth); end
    total++; if (bus.top !== 16'd0) begin bad++; $display("FAIL rst_top got=%h want=0", bus.top); end
    total++; if (bus.alu_func !== 4'd0) begin bad++; $display("FAIL rst_func got=%0d want=0", bus.alu_func); end
    total++; if (flags() !== 4'd0) begin bad++; $display("FAIL rst_flags got=%b want=0000", flags()); end
    rst = 1'b0;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", bus.cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_sub();
    int busy, exec_n; logic [3:0] f; logic [15:0] i0, i1;
    send(3'd0, 16'd5);
    total++; if (flags() !== 4'b1000) begin bad++; $display("FAIL push_done got=%b want=1000", flags()); end
    total++; if (bus.depth !== CW'(1)) begin bad++; $display("FAIL push_depth got=%0d want=1", bus.depth); end
    send(3'd0, 16'd3);
    send(3'd3, 16'd0);
    wait_done(busy, exec_n, f, i0, i1);
    total++; if (busy != 4) begin bad++; $display("FAIL sub_busy got=%0d want=4", busy); end
    total++; if (exec_n != 1) begin bad++; $display("FAIL sub_exec_cycles got=%0d want=1", exec_n); end
    total++; if (f !== 4'd3) begin bad++; $display("FAIL sub_func got=%0d want=3", f); end
    total++; if (i0 !== 16'd5 || i1 !== 16'd3) begin bad++; $display("FAIL sub_operands got=%0d,%0d want=5,3", i0, i1); end
    total++; if (bus.top !== 16'd2) begin bad++; $display("FAIL sub_top got=%0d want=2", bus.top); end
    total++; if (bus.depth !== CW'(1)) begin bad++; $display("FAIL sub_depth got=%0d want=1", bus.depth); end
    total++; if (flags() !== 4'b1000) begin bad++; $display("FAIL sub_done got=%b want=1000", flags()); end
    @(negedge clk);
    total++; if (flags() !== 4'b0000) begin bad++; $display("FAIL sub_done_pulse got=%b want=0000", flags()); end
  endtask

  task automatic test_wrap();
    int busy, exec_n; logic [3:0] f; logic [15:0] i0, i1;
    do_reset();
    send(3'd0, 16'h0100);
    send(3'd0, 16'h0100);
    send(3'd4, 16'd0);
    wait_done(busy, exec_n, f, i0, i1);
    total++; if (bus.top !== 16'h0000) begin bad++; $display("FAIL mul_wrap_top got=%h want=0000", bus.top); end
    total++; if (bus.depth !== CW'(1)) begin bad++; $display("FAIL mul_wrap_depth got=%0d want=1", bus.depth); end
    send(3'd0, 16'hFFFF);
    send(3'd2, 16'd0);
    wait_done(busy, exec_n, f, i0, i1);
    total++; if (bus.top !== 16'hFFFF) begin bad++; $display("FAIL add_top got=%h want=ffff", bus.top); end
    total++; if (bus.depth !== CW'(1)) begin bad++; $display("FAIL add_depth got=%0d want=1", bus.depth); end
  endtask

  task automatic test_underflow();
    do_reset();
    send(3'd1, 16'd0);
    total++; if (flags() !== 4'b0100) begin bad++; $display("FAIL pop_under got=%b want=0100", flags()); end
    total++; if (bus.depth !== CW'(0)) begin bad++; $display("FAIL pop_under_depth got=%0d want=0", bus.depth); end
    @(negedge clk);
    total++; if (flags() !== 4'b0000) begin bad++; $display("FAIL under_pulse got=%b want=0000", flags()); end
    send(3'd0, 16'h1234);
    send(3'd2, 16'd0);
    total++; if (flags() !== 4'b0100) begin bad++; $display("FAIL add_under got=%b want=0100", flags()); end
    total++; if (bus.depth !== CW'(1)) begin bad++; $display("FAIL add_under_depth got=%0d want=1", bus.depth); end
    total++; if (bus.top !== 16'h1234) begin bad++; $display("FAIL add_under_top got=%h want=1234", bus.top); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL add_under_ready got=%b want=1", bus.cmd_ready); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) send(3'd0, 16'(i));
    total++; if (bus.depth !== CW'(DEPTH)) begin bad++; $display("FAIL fill_depth got=%0d want=%0d", bus.depth, DEPTH); end
    send(3'd0, 16'hAAAA);
    total++; if (flags() !== 4'b0010) begin bad++; $display("FAIL over_flag got=%b want=0010", flags()); end
    total++; if (bus.depth !== CW'(DEPTH)) begin bad++; $display("FAIL over_depth got=%0d want=%0d", bus.depth, DEPTH); end
    total++; if (bus.top !== 16'(DEPTH)) begin bad++; $display("FAIL over_top got=%0d want=%0d", bus.top, DEPTH); end
    send(3'd1, 16'd0);
    total++; if (bus.top !== 16'(DEPTH - 1)) begin bad++; $display("FAIL pop_top got=%0d want=%0d", bus.top, DEPTH - 1); end
    total++; if (bus.depth !== CW'(DEPTH - 1)) begin bad++; $display("FAIL pop_depth got=%0d want=%0d", bus.depth, DEPTH - 1); end
  endtask

  task automatic test_div_ill_hold();
    int busy, exec_n; logic [3:0] f; logic [15:0] i0, i1;
    do_reset();
    send(3'd0, 16'd7);
    send(3'd0, 16'd2);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd5; bus.cmd_data = 16'd0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_op = 3'd0; bus.cmd_data = 16'h5555;
    wait_done(busy, exec_n, f, i0, i1);
    bus.cmd_valid = 1'b0;
    total++; if (busy != 4) begin bad++; $display("FAIL div_busy got=%0d want=4", busy); end
    total++; if (bus.top !== 16'd3) begin bad++; $display("FAIL div_top got=%0d want=3", bus.top); end
    total++; if (bus.depth !== CW'(1)) begin bad++; $display("FAIL hold_depth got=%0d want=1", bus.depth); end
    @(negedge clk);
    send(3'd6, 16'd0);
    total++; if (flags() !== 4'b0001) begin bad++; $display("FAIL ill6 got=%b want=0001", flags()); end
    total++; if (bus.depth !== CW'(1)) begin bad++; $display("FAIL ill6_depth got=%0d want=1", bus.depth); end
    send(3'd7, 16'd0);
    total++; if (flags() !== 4'b0001) begin bad++; $display("FAIL ill7 got=%b want=0001", flags()); end
    total++; if (bus.top !== 16'd3) begin bad++; $display("FAIL ill7_top got=%0d want=3", bus.top); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(3'd0, 16'd4);
    send(3'd0, 16'd9);
    send(3'd2, 16'd0);
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.alu_func !== 4'd2) begin bad++; $display("FAIL mid_exec_func got=%0d want=2", bus.alu_func); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.depth !== CW'(0)) begin bad++; $display("FAIL mid_depth got=%0d want=0", bus.depth); end
    total++; if (bus.top !== 16'd0) begin bad++; $display("FAIL mid_top got=%h want=0", bus.top); end
    total++; if (bus.op_done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b want=0", bus.op_done); end
    rst = 1'b0;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", bus.cmd_ready); end
    @(negedge clk);
    total++; if (flags() !== 4'b0000) begin bad++; $display("FAIL mid_after_flags got=%b want=0000", flags()); end
    mq.delete();
  endtask

  task automatic test_random();
    int busy, exec_n; logic [3:0] f; logic [15:0] i0, i1;
    logic [2:0] op; logic [15:0] d, exp_top; logic [3:0] exp_flags;
    int unsigned ai, bi, r; int rnd; bit arith_ok;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom_range(0, 99);
      if (rnd < 40) op = 3'd0;
      else if (rnd < 55) op = 3'd1;
      else if (rnd < 92) op = 3'($urandom_range(2, 5));
      else op = 3'($urandom_range(6, 7));
      d = 16'($urandom);
      arith_ok = 1'b0;
      exp_flags = 4'b0000;
      if (op == 3'd0) begin
        if (mq.size() < DEPTH) begin mq.push_back(d); exp_flags = 4'b1000; end
        else exp_flags = 4'b0010;
      end else if (op == 3'd1) begin
        if (mq.size() >= 1) begin void'(mq.pop_back()); exp_flags = 4'b1000; end
        else exp_flags = 4'b0100;
      end else if (op <= 3'd5) begin
        if (mq.size() < 2) exp_flags = 4'b0100;
        else begin
          bi = mq.pop_back();
          ai = mq.pop_back();
          case (op)
            3'd2: r = (ai + bi) % 65536;
            3'd3: r = (ai + 65536 - bi) % 65536;
            3'd4: r = (ai * bi) % 65536;
            default: r = (bi == 0) ? 65535 : ai / bi;
          endcase
          mq.push_back(16'(r));
          exp_flags = 4'b1000;
          arith_ok = 1'b1;
        end
      end else begin
        exp_flags = 4'b0001;
      end
      exp_top = (mq.size() == 0) ? 16'd0 : mq[$];
      send(op, d);
      if (arith_ok) begin
        wait_done(busy, exec_n, f, i0, i1);
        total++; if (busy != 4) begin bad++; $display("FAIL rnd_busy n=%0d got=%0d want=4", n, busy); end
      end
      total++; if (flags() !== exp_flags) begin bad++; $display("FAIL rnd_flags n=%0d op=%0d got=%b want=%b", n, op, flags(), exp_flags); end
      total++; if (bus.depth !== CW'(mq.size())) begin bad++; $display("FAIL rnd_depth n=%0d got=%0d want=%0d", n, bus.depth, mq.size()); end
      total++; if (bus.top !== exp_top) begin bad++; $display("FAIL rnd_top n=%0d got=%h want=%h", n, bus.top, exp_top); end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 16'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_sub();
    test_wrap();
    test_underflow();
    test_overflow();
    test_div_ill_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
